uart_mult_byte_tx: RTL and testbench
====================================

Name: uart_mult_byte_tx

Overview:
Frame transmitter paired with the multi-byte UART receiver.
- On a start pulse, latches an 11-byte payload and serialises one 14-byte frame: 0x55, payload[0..10], CRC8, 0xAA.
- Line format: 8N1, LSB first.
- Sits between the control/register logic and the board UART TX pin; returns status and readback data to the host.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate.
- DATA_NUM, 14, total frame bytes; payload count PAY_NUM = DATA_NUM-3 (11).
- BPS_CNT (localparam), CLK_FREQ/UART_BPS, clocks per bit (integer division).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-high reset.
- tx_start  in  1  single-cycle frame request; honoured only when not busy.
- tx_payload  in  PAY_NUM*8  payload; byte k = bits [8k+7:8k], byte 0 is sent first after the header.
- uart_txd  out  1  serial line; idle high.
- tx_busy  out  1  high from the accepting cycle until tx_done.
- tx_done  out  1  one-cycle pulse at end of frame.
- byte_idx  out  8  index of the byte currently on the line (0..DATA_NUM-1).
- crc_out  out  8  CRC of the last/current frame.

Behaviour:
- Reset (async, sys_rst_n=1):
  - uart_txd=1; tx_busy=0; tx_done=0; byte_idx=0; crc_out=0x00.
  - FSM=IDLE; all counters cleared.
  - Reset mid-frame aborts immediately; the line returns high.
- FSM states:
  - IDLE: uart_txd=1. tx_start=1 latches tx_payload into a shadow register, clears the CRC to 0x00, sets tx_busy=1, byte_idx=0, then -> LOAD.
  - LOAD (1 cycle): selects the byte. Index 0 = 0x55; 1..11 = payload[idx-1]; 12 = CRC; 13 = 0xAA. If idx is 1..11, the byte is folded into the CRC. -> SEND.
  - SEND: 10 bit slots of BPS_CNT cycles each.
    - Slot 0 = start (0); slots 1..8 = d0..d7; slot 9 = stop (1).
    - After slot 9 ends: idx==DATA_NUM-1 -> DONE; else idx+1 -> LOAD.
  - DONE (1 cycle): tx_done=1, tx_busy=0 -> IDLE.
- CRC8:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over payload bytes only.
  - Byte-parallel update in the LOAD cycle, so the CRC is final before index 12 is selected.
- Latency:
  - uart_txd falls (start bit) 2 cycles after tx_start is sampled (IDLE->LOAD->SEND).
  - Each byte occupies 10*BPS_CNT+1 cycles; the LOAD cycle holds the line high (stop extension).
- tx_start while tx_busy=1 is ignored (no queueing).
- tx_start in the same cycle as DONE is ignored; it is accepted from IDLE only.
- tx_payload changes after acceptance have no effect on the frame in progress.
- The bit counter wraps at BPS_CNT-1. The counter is 16 bits wide, so BPS_CNT must be ≤ 65535.

Optional Feature:
UART_TX_IDLE_GAP_EN
- Defined: a GAP state of BPS_CNT cycles with uart_txd=1 is inserted after every byte's stop bit, except the last byte.
- Undefined: bytes are back-to-back, separated only by the LOAD cycle.
- Frame length, CRC and port behaviour are otherwise unchanged.

Decomposition:
- Shared package uart_frame_pkg:
  - FRAME_HEAD=8'h55, FRAME_TAIL=8'hAA, CRC8_POLY=8'h07.
  - DATA_NUM default.
  - FSM state typedef/encoding.
  - crc8_byte function (8-bit state, 8-bit data -> 8-bit next state).
- One natural sub-module: uart_byte_tx.
  - Single-byte 8N1 shifter with start/busy/done and the BPS counter.
  - The parent FSM sequences bytes and the CRC.

Test Plan:
- Sim params CLK_FREQ=1_000_000, UART_BPS=100_000 (BPS_CNT=10).
  - All-zero payload, tx_start pulse -> line bytes 55,00×11,00,AA.
  - tx_done exactly 14*101+2 cycles after tx_start (per the latency/length rules above); crc_out=0x00.
- Payload zeros except byte 10=0x01 -> CRC byte 0x07, tail 0xAA.
  - Receiver loopback asserts recv_done and rev_data10=0x01.
- Payload 01..0B incrementing -> bench CRC model (poly 0x07) matches byte 12.
  - Each bit holds exactly 10 cycles; LSB first.
- Pulse tx_start again at byte_idx=5 with a different payload -> ignored; the frame completes with the original payload; tx_done fires once.
- Assert sys_rst_n at byte_idx=7, mid-bit.
  - uart_txd=1 and tx_busy=0 in the same cycle.
  - A new tx_start afterwards produces a complete, correct frame.
- With UART_TX_IDLE_GAP_EN defined:
  - Line-high gap of 10 cycles between stop bit and next start bit, 13 gaps in total.
  - Total frame length is 130 cycles longer than without the macro.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM encoding and CRC8 helper for the multi-byte UART frame logic.
// Optional build macro UART_TX_IDLE_GAP_EN is consumed by uart_mult_byte_tx.
package uart_frame_pkg;

    localparam logic [7:0]  FRAME_HEAD       = 8'h55;
    localparam logic [7:0]  FRAME_TAIL       = 8'hAA;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam int unsigned DATA_NUM_DEFAULT = 14;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StGap,
        StDone
    } frame_state_e;

    // Byte-parallel CRC8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_mult_byte_tx_byte.sv
// Single-byte 8N1 shifter, LSB first; done is high in the final cycle of the stop bit.
module uart_byte_tx #(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);

    logic        txd_q;
    logic        busy_q;
    logic [15:0] bps_cnt_q;
    logic [3:0]  slot_q;
    logic [7:0]  shift_q;

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            bps_cnt_q <= '0;
            slot_q    <= '0;
            shift_q   <= '0;
        end else if (!busy_q) begin
            if (start) begin
                shift_q   <= data;
                txd_q     <= 1'b0;
                busy_q    <= 1'b1;
                bps_cnt_q <= '0;
                slot_q    <= '0;
            end
        end else if (bps_cnt_q == BPS_LAST) begin
            bps_cnt_q <= '0;
            if (slot_q == 4'd9) begin
                busy_q <= 1'b0;
                txd_q  <= 1'b1;
            end else begin
                slot_q <= slot_q + 4'd1;
                // Slot n+1 carries data bit n; slot 9 is the stop bit.
                txd_q  <= (slot_q == 4'd8) ? 1'b1 : shift_q[slot_q[2:0]];
            end
        end else begin
            bps_cnt_q <= bps_cnt_q + 16'd1;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = busy_q && (slot_q == 4'd9) && (bps_cnt_q == BPS_LAST);

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Frame transmitter: 0x55, payload[0..PAY_NUM-1], CRC8, 0xAA over 8N1.
// Define UART_TX_IDLE_GAP_EN to insert one idle bit time after every byte but the last.
module uart_mult_byte_tx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 115200,
    parameter int unsigned DATA_NUM = DATA_NUM_DEFAULT
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      tx_start,
    input  logic [(DATA_NUM-3)*8-1:0] tx_payload,
    output logic                      uart_txd,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic [7:0]                byte_idx,
    output logic [7:0]                crc_out
);

    localparam int unsigned PAY_NUM = DATA_NUM - 3;
    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;

    frame_state_e             state_q;
    logic [PAY_NUM*8-1:0]     shadow_q;
    logic [7:0]               idx_q;
    logic [7:0]               crc_q;
    logic                     busy_q;
    logic                     done_q;
    logic [7:0]               cur_byte;
    logic [7:0]               pay_sel;
    logic [10:0]              bit_base;
    logic                     byte_start;
    logic                     byte_done;
    logic                     byte_busy;
`ifdef UART_TX_IDLE_GAP_EN
    logic [15:0]              gap_cnt_q;
`endif

    always_comb begin
        pay_sel  = idx_q - 8'd1;
        bit_base = {pay_sel, 3'b000};
        cur_byte = FRAME_HEAD;
        if (idx_q == 8'd0) begin
            cur_byte = FRAME_HEAD;
        end else if (idx_q <= 8'(PAY_NUM)) begin
            cur_byte = shadow_q[bit_base +: 8];
        end else if (idx_q == 8'(PAY_NUM + 1)) begin
            cur_byte = crc_q;
        end else begin
            cur_byte = FRAME_TAIL;
        end
    end

    assign byte_start = (state_q == StLoad);

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            idx_q     <= '0;
            crc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_IDLE_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tx_start) begin
                        shadow_q <= tx_payload;
                        crc_q    <= 8'h00;
                        busy_q   <= 1'b1;
                        idx_q    <= '0;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    // Folding here makes the CRC final before the CRC byte is selected.
                    if (idx_q >= 8'd1 && idx_q <= 8'(PAY_NUM)) begin
                        crc_q <= crc8_byte(crc_q, cur_byte);
                    end
                    state_q <= StSend;
                end
                StSend: begin
                    if (byte_done) begin
                        if (idx_q == 8'(DATA_NUM - 1)) begin
                            state_q <= StDone;
                        end else begin
`ifdef UART_TX_IDLE_GAP_EN
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
`else
                            idx_q   <= idx_q + 8'd1;
                            state_q <= StLoad;
`endif
                        end
                    end
                end
`ifdef UART_TX_IDLE_GAP_EN
                StGap: begin
                    if (gap_cnt_q == 16'(BPS_CNT - 1)) begin
                        idx_q   <= idx_q + 8'd1;
                        state_q <= StLoad;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
`endif
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (byte_start),
        .data      (cur_byte),
        .txd       (uart_txd),
        .busy      (byte_busy),
        .done      (byte_done)
    );

    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign byte_idx = idx_q;
    assign crc_out  = crc_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Directed bench for uart_mult_byte_tx: captures the line per cycle and decodes each frame.
module tb_uart_mult_byte_tx;

    localparam int MAXC = 2000;
`ifdef UART_TX_IDLE_GAP_EN
    localparam int PER = 111;
`else
    localparam int PER = 101;
`endif
    localparam int DONE_AT = 2 + 13 * PER + 101;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        tx_start = 1'b0;
    logic [87:0] tx_payload = '0;
    logic        uart_txd;
    logic        tx_busy;
    logic        tx_done;
    logic [7:0]  byte_idx;
    logic [7:0]  crc_out;

    int checks = 0;
    int failures = 0;

    logic       txd_tr  [0:MAXC-1];
    logic       busy_tr [0:MAXC-1];
    logic [7:0] rx      [0:13];

    always #5 sys_clk = ~sys_clk;

    uart_mult_byte_tx #(
        .CLK_FREQ (1_000_000),
        .UART_BPS (100_000),
        .DATA_NUM (14)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_start   (tx_start),
        .tx_payload (tx_payload),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .byte_idx   (byte_idx),
        .crc_out    (crc_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference CRC8 (poly 0x07, init 0).
    function automatic logic [7:0] crc_model(input logic [87:0] pay);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k < 11; k++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ pay[8*k + b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Cycle 0 is the cycle with tx_start high; trace[n] is the line during cycle n.
    task automatic run_frame(input logic [87:0] pay, input logic [87:0] alt, input bit retrig,
                             output int done_cycle, output int done_count);
        bit sent;
        sent       = 1'b0;
        done_cycle = -1;
        done_count = 0;
        @(negedge sys_clk);
        tx_payload = pay;
        tx_start   = 1'b1;
        txd_tr[0]  = uart_txd;
        busy_tr[0] = tx_busy;
        for (int n = 1; n < MAXC; n++) begin
            @(negedge sys_clk);
            tx_start   = 1'b0;
            txd_tr[n]  = uart_txd;
            busy_tr[n] = tx_busy;
            if (tx_done) begin
                if (done_cycle < 0) done_cycle = n;
                done_count++;
            end
            if (retrig && !sent && byte_idx == 8'd5) begin
                tx_payload = alt;
                tx_start   = 1'b1;
                sent       = 1'b1;
            end
            if (done_cycle >= 0 && n >= done_cycle + 20) break;
        end
    endtask

    task automatic decode(output int glitches);
        int   s;
        logic v;
        glitches = 0;
        for (int k = 0; k < 14; k++) begin
            s = 2 + k * PER;
            rx[k] = 8'h00;
            if (txd_tr[s-1] !== 1'b1) glitches++;
            for (int slot = 0; slot < 10; slot++) begin
                v = txd_tr[s + slot*10];
                for (int c = 0; c < 10; c++) begin
                    if (txd_tr[s + slot*10 + c] !== v) glitches++;
                end
                if (slot == 0 && v !== 1'b0) glitches++;
                if (slot == 9 && v !== 1'b1) glitches++;
                if (slot >= 1 && slot <= 8) rx[k][slot-1] = v;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [87:0] pay,
                               input int done_cycle, input int done_count);
        int         g;
        logic [7:0] exp_crc;
        exp_crc = crc_model(pay);
        decode(g);
        check_eq({tag, "_glitch"}, g, 0);
        check_eq({tag, "_done_cycle"}, done_cycle, DONE_AT);
        check_eq({tag, "_done_count"}, done_count, 1);
        check_eq({tag, "_head"}, {24'h0, rx[0]}, 32'h55);
        for (int k = 0; k < 11; k++) begin
            check_eq($sformatf("%s_pay%0d", tag, k), {24'h0, rx[k+1]}, {24'h0, pay[8*k +: 8]});
        end
        check_eq({tag, "_crc_byte"}, {24'h0, rx[12]}, {24'h0, exp_crc});
        check_eq({tag, "_tail"}, {24'h0, rx[13]}, 32'hAA);
        check_eq({tag, "_crc_out"}, {24'h0, crc_out}, {24'h0, exp_crc});
        check_eq({tag, "_line_c1"}, {31'h0, txd_tr[1]}, 1);
        check_eq({tag, "_line_c2"}, {31'h0, txd_tr[2]}, 0);
        check_eq({tag, "_busy_c1"}, {31'h0, busy_tr[1]}, 1);
        if (done_cycle > 0 && done_cycle < MAXC) begin
            check_eq({tag, "_busy_pre_done"}, {31'h0, busy_tr[done_cycle-1]}, 1);
            check_eq({tag, "_busy_at_done"}, {31'h0, busy_tr[done_cycle]}, 0);
        end
    endtask

    initial begin
        logic [87:0] p_zero, p_one, p_inc;
        int dc, dn;
        bit found;
        p_zero = '0;
        p_one  = 88'h01 << 80;
        p_inc  = 88'h0B0A_0908_0706_0504_0302_01;

        repeat (3) @(negedge sys_clk);
        check_eq("rst_txd", {31'h0, uart_txd}, 1);
        check_eq("rst_busy", {31'h0, tx_busy}, 0);
        check_eq("rst_done", {31'h0, tx_done}, 0);
        check_eq("rst_idx", {24'h0, byte_idx}, 0);
        check_eq("rst_crc", {24'h0, crc_out}, 0);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);

        run_frame(p_zero, '0, 1'b0, dc, dn);
        check_frame("zero", p_zero, dc, dn);
        check_eq("zero_crc_val", {24'h0, crc_out}, 32'h00);

        run_frame(p_one, '0, 1'b0, dc, dn);
        check_frame("one", p_one, dc, dn);
        check_eq("one_crc_val", {24'h0, rx[12]}, 32'h07);
        check_eq("one_byte10", {24'h0, rx[11]}, 32'h01);

        run_frame(p_inc, '0, 1'b0, dc, dn);
        check_frame("inc", p_inc, dc, dn);

        run_frame(p_inc, {88{1'b1}}, 1'b1, dc, dn);
        check_frame("retrig", p_inc, dc, dn);

        // Abort mid start bit of byte 7.
        @(negedge sys_clk);
        tx_payload = p_inc;
        tx_start   = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            if (byte_idx == 8'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check_eq("abort_reach_idx7", {31'h0, found}, 1);
        repeat (5) @(negedge sys_clk);
        check_eq("abort_pre_txd", {31'h0, uart_txd}, 0);
        #2 sys_rst_n = 1'b1;
        #1;
        check_eq("abort_txd", {31'h0, uart_txd}, 1);
        check_eq("abort_busy", {31'h0, tx_busy}, 0);
        check_eq("abort_idx", {24'h0, byte_idx}, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);

        run_frame(p_inc, '0, 1'b0, dc, dn);
        check_frame("after_abort", p_inc, dc, dn);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
